// File: rtl/rv32_branch_predictor.sv
// ----------------------------------------------------------------------------
// rv32_branch_predictor
//
// Dynamic branch predictor for the 5-stage RV32I pipeline. IF stage does a
// combinational lookup into a direct-mapped BTB; EX stage resolves the
// control-transfer outcome, trains the BTB (2-bit bimodal counters) and
// produces the mispredict / redirect pair that flushes IF/ID and ID/EX.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_pc, if_valid     fetch PC and slot-valid qualifier
//   pred_taken          predicted taken for if_pc
//   pred_next_pc        BTB target when predicted taken, else if_pc+4
//   ex_valid            EX holds a real instruction
//   ex_pc, ex_is_cti    EX PC and branch/JAL/JALR flag
//   ex_taken, ex_target resolved outcome and target
//   ex_pred_taken/target  prediction carried down the pipe with the instr
//   mispredict          flush request, take redirect_pc
//   redirect_pc         correct next PC for the EX instruction
//   stat_cti, stat_miss saturating performance counters
//
// Interface qualifiers: there is no backpressure. if_valid and ex_valid are
// plain qualifiers sampled every cycle; a cycle with ex_valid=1 is one
// resolved instruction and is consumed unconditionally at the rising edge.
// ----------------------------------------------------------------------------
module rv32_branch_predictor #(
    parameter int          XLEN     = 32,
    parameter int          ENTRIES  = 64,
    parameter int          TAG_W    = 8,
    parameter int          MODE     = 1,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int          STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    input  logic              if_valid,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_next_pc,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_is_cti,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_cti,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam bit MODE_EN = (MODE != 0);

    // BTB storage. Only valid and ctr need a reset value; tag/target are
    // qualified by valid.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [STAT_W-1:0]  stat_cti_q;
    logic [STAT_W-1:0]  stat_miss_q;

    // IF-side index/tag
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    // EX-side index/tag
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ex_cti_v;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update to the
    // same entry is seen one cycle later.
    assign if_hit = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
    assign ex_hit = ex_valid & valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

    always_comb begin
        pred_taken   = MODE_EN & if_hit & ctr_q[if_idx][1];
        pred_next_pc = if_pc + XLEN'(4);
        if (pred_taken) begin
            pred_next_pc = target_q[if_idx];
        end
    end

    assign ex_cti_v = ex_valid & ex_is_cti;

    // A wrong target only matters when the instruction actually went taken.
    // A non-CTI that was predicted taken (BTB alias) also needs a flush.
    always_comb begin
        mispredict = (ex_cti_v & ((ex_taken != ex_pred_taken) |
                                  (ex_taken & (ex_target != ex_pred_target))))
                   | (ex_valid & ~ex_is_cti & ex_pred_taken);
        redirect_pc = ex_pc + XLEN'(4);
        if (ex_cti_v & ex_taken) begin
            redirect_pc = ex_target;
        end
    end

    // Table update: one write port, driven from EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CNT_INIT;
            end
        end else if (MODE_EN) begin
            if (ex_cti_v) begin
                if (ex_hit) begin
                    if (ex_taken) begin
                        if (ctr_q[ex_idx] != 2'b11) begin
                            ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                        end
                        target_q[ex_idx] <= ex_target;
                    end else if (ctr_q[ex_idx] != 2'b00) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                    end
                end else if (ex_taken) begin
                    // Allocate (or evict the aliasing entry) weakly taken.
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= ex_target;
                    ctr_q[ex_idx]    <= 2'b10;
                end
            end else if (ex_hit) begin
                // A non-CTI matched an entry: drop it so it stops predicting.
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cti_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            if (ex_cti_v && (stat_cti_q != '1)) begin
                stat_cti_q <= stat_cti_q + STAT_W'(1);
            end
            if (mispredict && (stat_miss_q != '1)) begin
                stat_miss_q <= stat_miss_q + STAT_W'(1);
            end
        end
    end

    assign stat_cti  = stat_cti_q;
    assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_rv32_branch_predictor
//
// Bench for rv32_branch_predictor. Two instances share the stimulus: the
// default bimodal configuration (dut) and a static not-taken build with
// 4-bit statistics (dut0). Resolution logic is checked from a vector table
// while reset is held; multi-cycle training, aliasing and saturation are
// checked by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_rv32_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_cti;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        pred_taken,  pred_taken0;
    logic [31:0] pred_next_pc, pred_next_pc0;
    logic        mispredict,  mispredict0;
    logic [31:0] redirect_pc, redirect_pc0;
    logic [31:0] stat_cti,    stat_miss;
    logic [3:0]  stat_cti0,   stat_miss0;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rv32_branch_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_cti(ex_is_cti),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_cti(stat_cti), .stat_miss(stat_miss)
    );

    rv32_branch_predictor #(.MODE(0), .STAT_W(4)) dut0 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid),
        .pred_taken(pred_taken0), .pred_next_pc(pred_next_pc0),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_cti(ex_is_cti),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict0), .redirect_pc(redirect_pc0),
        .stat_cti(stat_cti0), .stat_miss(stat_miss0)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic cti,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_is_cti      = cti;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic clear_ex();
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_lookup(input string name, input logic exp_tk, input logic [31:0] exp_nx);
        check({name, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        check({name, "_next_pc"}, pred_next_pc, exp_nx);
    endtask

    task automatic check_stats(input string name, input logic [31:0] cti, input logic [31:0] miss);
        check({name, "_stat_cti"}, stat_cti, cti);
        check({name, "_stat_miss"}, stat_miss, miss);
    endtask

    // ---------------- resolution vector table ----------------
    typedef struct {
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic        ex_is_cti;
        logic        ex_taken;
        logic [31:0] ex_target;
        logic        ex_pred_taken;
        logic [31:0] ex_pred_target;
        logic [31:0] if_pc;
        logic        exp_mis;
        logic [31:0] exp_redir;
        logic [31:0] exp_next;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic cti,
                                input logic tk, input logic [31:0] tgt,
                                input logic ptk, input logic [31:0] ptgt,
                                input logic [31:0] ipc, input logic mis,
                                input logic [31:0] redir, input logic [31:0] nx);
        vec_t r;
        r.ex_valid = v; r.ex_pc = pc; r.ex_is_cti = cti; r.ex_taken = tk;
        r.ex_target = tgt; r.ex_pred_taken = ptk; r.ex_pred_target = ptgt;
        r.if_pc = ipc; r.exp_mis = mis; r.exp_redir = redir; r.exp_next = nx;
        return r;
    endfunction

    vec_t vecs[10];

    initial begin
        //               v  pc            cti tk target        ptk ptarget       if_pc         mis redirect      next
        vecs[0] = mk(1, 32'h100,      1, 1, 32'h80,      0, 32'h104,     32'h100,      1, 32'h80,       32'h104);
        vecs[1] = mk(1, 32'h100,      1, 1, 32'h80,      1, 32'h80,      32'h200,      0, 32'h80,       32'h204);
        vecs[2] = mk(1, 32'h100,      1, 1, 32'h80,      1, 32'h90,      32'h0,        1, 32'h80,       32'h4);
        vecs[3] = mk(1, 32'h100,      1, 0, 32'h80,      0, 32'h104,     32'h100,      0, 32'h104,      32'h104);
        vecs[4] = mk(1, 32'h100,      1, 0, 32'h80,      1, 32'h80,      32'h100,      1, 32'h104,      32'h104);
        vecs[5] = mk(1, 32'h200,      0, 0, 32'h0,       1, 32'h80,      32'h100,      1, 32'h204,      32'h104);
        vecs[6] = mk(0, 32'h200,      0, 0, 32'h0,       1, 32'h80,      32'h100,      0, 32'h204,      32'h104);
        vecs[7] = mk(1, 32'h200,      0, 0, 32'h0,       0, 32'h204,     32'hFFFF_FFFC, 0, 32'h204,     32'h0);
        vecs[8] = mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0,      0, 32'h0,       32'hFFFF_FFF8, 0, 32'h0,       32'hFFFF_FFFC);
        vecs[9] = mk(1, 32'h100,      1, 0, 32'h80,      0, 32'h999,     32'h100,      0, 32'h104,      32'h104);

        rst      = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h100;
        clear_ex();
        tick();

        // Resolution is purely combinational; holding reset keeps the table
        // and statistics untouched while the vectors are applied.
        for (int i = 0; i < 10; i++) begin
            drive_ex(vecs[i].ex_valid, vecs[i].ex_pc, vecs[i].ex_is_cti, vecs[i].ex_taken,
                     vecs[i].ex_target, vecs[i].ex_pred_taken, vecs[i].ex_pred_target);
            if_pc = vecs[i].if_pc;
            #1;
            exp_q.push_back(vecs[i].exp_redir);
            check($sformatf("vec%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d_redirect", i), redirect_pc, exp_q.pop_front());
            check_lookup($sformatf("vec%0d", i), 1'b0, vecs[i].exp_next);
            tick();
        end

        // ---- reset state ----
        clear_ex();
        if_pc = 32'h100;
        tick();
        rst = 1'b0;
        tick();
        check_lookup("reset", 1'b0, 32'h104);
        check_stats("reset", 32'd0, 32'd0);

        // ---- first allocation, same-cycle lookup still misses ----
        drive_ex(1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        #1;
        check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        check("alloc_redirect", redirect_pc, 32'h80);
        check_lookup("alloc_same_cycle", 1'b0, 32'h104);
        tick();
        clear_ex();
        #1;
        check_lookup("alloc_next_cycle", 1'b1, 32'h80);
        check_stats("alloc", 32'd1, 32'd1);

        // ---- train to strongly taken (10 -> 11 -> 11) ----
        for (int i = 0; i < 2; i++) begin
            drive_ex(1, 32'h100, 1, 1, 32'h80, 1, 32'h80);
            #1;
            check($sformatf("train%0d_mispredict", i), {31'd0, mispredict}, 32'd0);
            tick();
        end
        clear_ex();
        #1;
        check_stats("trained", 32'd3, 32'd1);

        // ---- loop exit: 11 -> 10 still predicts taken ----
        drive_ex(1, 32'h100, 1, 0, 32'h80, 1, 32'h80);
        #1;
        check("exit1_mispredict", {31'd0, mispredict}, 32'd1);
        check("exit1_redirect", redirect_pc, 32'h104);
        tick();
        clear_ex();
        #1;
        check_lookup("exit1", 1'b1, 32'h80);
        check_stats("exit1", 32'd4, 32'd2);

        // ---- second not-taken: 10 -> 01 predicts not-taken ----
        drive_ex(1, 32'h100, 1, 0, 32'h80, 1, 32'h80);
        tick();
        clear_ex();
        #1;
        check_lookup("exit2", 1'b0, 32'h104);
        check_stats("exit2", 32'd5, 32'd3);

        // ---- alias: same index, different tag must not hit ----
        if_pc = 32'h200;
        #1;
        check_lookup("alias", 1'b0, 32'h204);

        // ---- retrain 01 -> 10 on hit ----
        if_pc = 32'h100;
        drive_ex(1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        tick();
        clear_ex();
        #1;
        check_lookup("retrain", 1'b1, 32'h80);
        check_stats("retrain", 32'd6, 32'd4);

        // ---- non-CTI predicted taken with ex_valid=0: nothing happens ----
        drive_ex(0, 32'h100, 0, 0, 32'h0, 1, 32'h80);
        #1;
        check("bubble_mispredict", {31'd0, mispredict}, 32'd0);
        tick();
        clear_ex();
        #1;
        check_lookup("bubble", 1'b1, 32'h80);
        check_stats("bubble", 32'd6, 32'd4);

        // ---- non-CTI predicted taken: flush and invalidate ----
        drive_ex(1, 32'h100, 0, 0, 32'h0, 1, 32'h80);
        #1;
        check("noncti_mispredict", {31'd0, mispredict}, 32'd1);
        check("noncti_redirect", redirect_pc, 32'h104);
        tick();
        clear_ex();
        #1;
        check_lookup("noncti_invalidated", 1'b0, 32'h104);
        check_stats("noncti", 32'd6, 32'd5);

        // ---- static mode, 4-bit stats saturate at 15 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_ex(1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
            #1;
            check($sformatf("static%0d_pred_taken", i), {31'd0, pred_taken0}, 32'd0);
            check($sformatf("static%0d_next_pc", i), pred_next_pc0, 32'h104);
            check($sformatf("static%0d_mispredict", i), {31'd0, mispredict0}, 32'd1);
            tick();
            check($sformatf("static%0d_stat_miss", i), {28'd0, stat_miss0},
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("static_stat_cti", {28'd0, stat_cti0}, 32'd15);
        check_lookup("bimodal_after_stream", 1'b1, 32'h80);

        // ---- reset mid-stream overrides the same-cycle update ----
        rst = 1'b1;
        drive_ex(1, 32'h100, 1, 1, 32'h80, 0, 32'h104);
        tick();
        check("midreset_stat_miss0", {28'd0, stat_miss0}, 32'd0);
        check("midreset_stat_cti0", {28'd0, stat_cti0}, 32'd0);
        check_stats("midreset", 32'd0, 32'd0);
        rst = 1'b0;
        clear_ex();
        #1;
        check_lookup("midreset", 1'b0, 32'h104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case something wedges the sequence.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
